// File: rtl/spclk_frame_tracker_pkg.sv
// Shared constants and state encoding for the spclk frame tracker.
package spclk_frame_tracker_pkg;

    localparam int unsigned FRAME_LEN       = 512;
    localparam int unsigned SAMPLE_IDX_NBIT = 9;
    localparam int unsigned TIMEOUT_CYC     = 1000;
    localparam int unsigned TIMEOUT_NBIT    = 10;
    localparam int unsigned FRAME_CNT_NBIT  = 16;
    localparam int unsigned ERR_CNT_NBIT    = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_HUNT   = 2'd0;
    localparam state_t ST_LOCKED = 2'd1;
    localparam state_t ST_LOST   = 2'd2;

    localparam logic [SAMPLE_IDX_NBIT-1:0] IDX_LAST = SAMPLE_IDX_NBIT'(FRAME_LEN - 1);
    localparam logic [TIMEOUT_NBIT-1:0]    TMO_LAST = TIMEOUT_NBIT'(TIMEOUT_CYC - 1);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/spclk_frame_tracker_sync_2ff.sv
// Two-stage synchronizer for a single asynchronous pin, async active-low reset.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/spclk_frame_tracker.sv
// Tracks 512-sample frames framed by sync on spclk rising edges (mclk domain).
// Optional SPCLK_GLITCH_FILTER_EN adds a 3-sample majority filter on both pins.
module spclk_frame_tracker
    import spclk_frame_tracker_pkg::*;
(
    input  logic                       mclk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic                       sync_in,
    input  logic                       spclk_in,
    output logic                       sample_stb,
    output logic                       frame_sop,
    output logic [SAMPLE_IDX_NBIT-1:0] sample_idx,
    output logic [FRAME_CNT_NBIT-1:0]  frame_cnt,
    output logic                       locked,
    output logic                       err_short,
    output logic                       err_long,
    output logic                       err_timeout,
    output logic [ERR_CNT_NBIT-1:0]    err_cnt
);

    logic spclk_s2;
    logic sync_s2;
    logic spclk_cur;
    logic sync_cur;
    logic spclk_prev_q;
    logic edge_det;

    sync_2ff u_sync_spclk (
        .clk_i  (mclk),
        .rst_ni (reset_n),
        .d_i    (spclk_in),
        .q_o    (spclk_s2)
    );

    sync_2ff u_sync_frame (
        .clk_i  (mclk),
        .rst_ni (reset_n),
        .d_i    (sync_in),
        .q_o    (sync_s2)
    );

`ifdef SPCLK_GLITCH_FILTER_EN
    logic [1:0] spclk_hist_q;
    logic [1:0] sync_hist_q;
    logic       spclk_flt_q;
    logic       sync_flt_q;

    // Registered majority output keeps sync aligned with spclk and adds the two extra cycles.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            spclk_hist_q <= '0;
            sync_hist_q  <= '0;
            spclk_flt_q  <= 1'b0;
            sync_flt_q   <= 1'b0;
        end else begin
            spclk_hist_q <= {spclk_hist_q[0], spclk_s2};
            sync_hist_q  <= {sync_hist_q[0], sync_s2};
            spclk_flt_q  <= maj3(spclk_s2, spclk_hist_q[0], spclk_hist_q[1]);
            sync_flt_q   <= maj3(sync_s2, sync_hist_q[0], sync_hist_q[1]);
        end
    end

    assign spclk_cur = spclk_flt_q;
    assign sync_cur  = sync_flt_q;
`else
    assign spclk_cur = spclk_s2;
    assign sync_cur  = sync_s2;
`endif

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            spclk_prev_q <= 1'b0;
        end else begin
            spclk_prev_q <= spclk_cur;
        end
    end

    assign edge_det = spclk_cur & ~spclk_prev_q;

    state_t                     state_q, state_d;
    logic [SAMPLE_IDX_NBIT-1:0] idx_q, idx_d;
    logic [FRAME_CNT_NBIT-1:0]  frame_cnt_q, frame_cnt_d;
    logic [TIMEOUT_NBIT-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [ERR_CNT_NBIT-1:0]    err_cnt_q, err_cnt_d;
    logic                       stb_q, stb_d;
    logic                       sop_q, sop_d;
    logic                       short_q, short_d;
    logic                       long_q, long_d;
    logic                       tmo_q, tmo_d;

    // An edge takes priority over a timeout in the same cycle.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        stb_d       = 1'b0;
        sop_d       = 1'b0;
        short_d     = 1'b0;
        long_d      = 1'b0;
        tmo_d       = 1'b0;
        if (!en) begin
            state_d = ST_HUNT;
            idx_d   = '0;
        end else if (edge_det) begin
            case (state_q)
                ST_HUNT: begin
                    if (sync_cur) begin
                        state_d = ST_LOCKED;
                        idx_d   = '0;
                        stb_d   = 1'b1;
                        sop_d   = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (sync_cur) begin
                        if (idx_q == IDX_LAST) begin
                            frame_cnt_d = frame_cnt_q + FRAME_CNT_NBIT'(1);
                        end else begin
                            short_d = 1'b1;
                        end
                        idx_d = '0;
                        stb_d = 1'b1;
                        sop_d = 1'b1;
                    end else if (idx_q != IDX_LAST) begin
                        idx_d = idx_q + SAMPLE_IDX_NBIT'(1);
                        stb_d = 1'b1;
                    end else begin
                        long_d  = 1'b1;
                        state_d = ST_HUNT;
                        idx_d   = '0;
                    end
                end
                ST_LOST: begin
                    state_d = ST_HUNT;
                    idx_d   = '0;
                end
                default: begin
                    state_d = ST_HUNT;
                    idx_d   = '0;
                end
            endcase
        end else if (state_q == ST_LOCKED && tmo_cnt_q == TMO_LAST) begin
            tmo_d   = 1'b1;
            state_d = ST_LOST;
            idx_d   = '0;
        end
    end

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (edge_det) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != '1) begin
            tmo_cnt_d = tmo_cnt_q + TIMEOUT_NBIT'(1);
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((short_d | long_d | tmo_d) && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_CNT_NBIT'(1);
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HUNT;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            err_cnt_q   <= '0;
            stb_q       <= 1'b0;
            sop_q       <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_cnt_q   <= err_cnt_d;
            stb_q       <= stb_d;
            sop_q       <= sop_d;
            short_q     <= short_d;
            long_q      <= long_d;
            tmo_q       <= tmo_d;
        end
    end

    assign sample_stb  = stb_q;
    assign frame_sop   = sop_q;
    assign sample_idx  = idx_q;
    assign frame_cnt   = frame_cnt_q;
    assign locked      = (state_q == ST_LOCKED);
    assign err_short   = short_q;
    assign err_long    = long_q;
    assign err_timeout = tmo_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_spclk_frame_tracker.sv
// Self-checking bench for spclk_frame_tracker; sample clock is accelerated to a few mclk cycles.
// Build with SPCLK_GLITCH_FILTER_EN to exercise the filtered variant.
module tb_spclk_frame_tracker;

`ifdef SPCLK_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic        mclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic        sync_in = 1'b0;
    logic        spclk_in = 1'b0;
    logic        sample_stb, frame_sop, locked;
    logic        err_short, err_long, err_timeout;
    logic [8:0]  sample_idx;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_edge_cyc = 0;
    int stb_seen = 0;

    // Reference state, kept at the level of "what an accepted sample-clock edge does"
    bit m_locked = 0;
    bit m_lost = 0;
    int m_idx = 0;
    int m_frames = 0;
    int m_errs = 0;
    bit e_stb, e_sop, e_short, e_long;

    spclk_frame_tracker dut (
        .mclk        (mclk),
        .reset_n     (reset_n),
        .en          (en),
        .sync_in     (sync_in),
        .spclk_in    (spclk_in),
        .sample_stb  (sample_stb),
        .frame_sop   (frame_sop),
        .sample_idx  (sample_idx),
        .frame_cnt   (frame_cnt),
        .locked      (locked),
        .err_short   (err_short),
        .err_long    (err_long),
        .err_timeout (err_timeout),
        .err_cnt     (err_cnt)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) begin
        cyc++;
        if (sample_stb === 1'b1) stb_seen++;
    end

    initial begin
        repeat (300000) @(posedge mclk);
        $display("FAIL watchdog: cycle budget exhausted, got %0d cycles, required fewer", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int exp_err_cnt();
        return (m_errs > 255) ? 255 : m_errs;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_lost = 0; m_idx = 0; m_frames = 0; m_errs = 0;
    endtask

    task automatic model_edge(input bit s);
        e_stb = 0; e_sop = 0; e_short = 0; e_long = 0;
        if (!en) return;
        if (m_lost) begin
            m_lost = 0;
        end else if (!m_locked) begin
            if (s) begin
                m_locked = 1; m_idx = 0; e_stb = 1; e_sop = 1;
            end
        end else if (s) begin
            if (m_idx == 511) m_frames = (m_frames + 1) % 65536;
            else begin e_short = 1; m_errs++; end
            m_idx = 0; e_stb = 1; e_sop = 1;
        end else if (m_idx < 511) begin
            m_idx++; e_stb = 1;
        end else begin
            e_long = 1; m_errs++; m_locked = 0; m_idx = 0;
        end
    endtask

    // Entered right after a negedge; raises spclk for hi cycles then holds it low for lo cycles.
    task automatic do_edge(input bit s, input int hi, input int lo);
        model_edge(s);
        spclk_in = 1'b1;
        sync_in  = s;
        for (int k = 1; k <= hi + lo; k++) begin
            @(negedge mclk);
            tests++;
            if (k == LAT) begin
                last_edge_cyc = cyc;
                if ({sample_stb, frame_sop, err_short, err_long, err_timeout} !==
                    {e_stb, e_sop, e_short, e_long, 1'b0}) begin
                    fails++;
                    $display("FAIL edge_flags: stb/sop/short/long/tmo got %b%b%b%b%b required %b%b%b%b0",
                             sample_stb, frame_sop, err_short, err_long, err_timeout,
                             e_stb, e_sop, e_short, e_long);
                end
                tests++;
                if (frame_cnt !== 16'(m_frames)) begin
                    fails++;
                    $display("FAIL frame_cnt: got %0d required %0d", frame_cnt, m_frames);
                end
                tests++;
                if (err_cnt !== 8'(exp_err_cnt())) begin
                    fails++;
                    $display("FAIL err_cnt: got %0d required %0d", err_cnt, exp_err_cnt());
                end
                tests++;
                if (locked !== m_locked) begin
                    fails++;
                    $display("FAIL locked: got %b required %b", locked, m_locked);
                end
                if (m_locked) begin
                    tests++;
                    if (sample_idx !== 9'(m_idx)) begin
                        fails++;
                        $display("FAIL sample_idx: got %0d required %0d", sample_idx, m_idx);
                    end
                end
            end else if (sample_stb !== 1'b0) begin
                fails++;
                $display("FAIL stb_timing: got stb=%b at cycle %0d after pin edge, required 0", sample_stb, k);
            end
            if (k == hi) begin
                spclk_in = 1'b0;
                sync_in  = 1'b0;
            end
        end
    endtask

    task automatic rnd_edge(input bit s);
        do_edge(s, 3 + $urandom_range(2), 3 + $urandom_range(2));
    endtask

    task automatic stall(input int n);
        bit exp_to;
        for (int k = 0; k < n; k++) begin
            @(negedge mclk);
            exp_to = m_locked && (cyc - last_edge_cyc == 1000);
            if (exp_to) begin
                m_locked = 0; m_lost = 1; m_idx = 0; m_errs++;
            end
            tests++;
            if ({err_timeout, locked} !== {exp_to, m_locked}) begin
                fails++;
                $display("FAIL timeout: tmo/locked got %b%b required %b%b at %0d cycles after edge",
                         err_timeout, locked, exp_to, m_locked, cyc - last_edge_cyc);
            end
            if (exp_to) begin
                tests++;
                if (err_cnt !== 8'(exp_err_cnt())) begin
                    fails++;
                    $display("FAIL timeout_err_cnt: got %0d required %0d", err_cnt, exp_err_cnt());
                end
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        tests++;
        if ({sample_stb, frame_sop, sample_idx, frame_cnt, locked,
             err_short, err_long, err_timeout, err_cnt} !== '0) begin
            fails++;
            $display("FAIL %s: outputs stb=%b sop=%b idx=%0d fc=%0d lk=%b es=%b el=%b et=%b ec=%0d required all 0",
                     name, sample_stb, frame_sop, sample_idx, frame_cnt, locked,
                     err_short, err_long, err_timeout, err_cnt);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b0;
        repeat (3) @(negedge mclk);
        check_all_zero("reset_hold");
        reset_n = 1'b1;
        @(negedge mclk);
        check_all_zero("reset_release");
        model_reset();
        en = 1'b1;
        @(negedge mclk);
    endtask

    task automatic test_frames();
        int s0;
        repeat (3) rnd_edge(1'b0);
        rnd_edge(1'b1);
        for (int f = 0; f < 3; f++) begin
            s0 = stb_seen;
            repeat (511) rnd_edge(1'b0);
            tests++;
            if (stb_seen - s0 !== 511) begin
                fails++;
                $display("FAIL frame_strobes: got %0d required 511 after sop", stb_seen - s0);
            end
            rnd_edge(1'b1);
        end
        tests++;
        if ({frame_cnt, err_cnt} !== {16'd3, 8'd0}) begin
            fails++;
            $display("FAIL three_frames: frame_cnt %0d err_cnt %0d required 3 and 0", frame_cnt, err_cnt);
        end
    endtask

    task automatic test_short();
        repeat (300) rnd_edge(1'b0);
        rnd_edge(1'b1);
        tests++;
        if ({err_cnt, locked, sample_idx} !== {8'd1, 1'b1, 9'd0}) begin
            fails++;
            $display("FAIL short_sync: err_cnt %0d locked %b idx %0d required 1 1 0", err_cnt, locked, sample_idx);
        end
    endtask

    task automatic test_long();
        repeat (511) rnd_edge(1'b0);
        rnd_edge(1'b0);
        repeat (2) rnd_edge(1'b0);
        rnd_edge(1'b1);
    endtask

    task automatic test_timeout();
        repeat (5) rnd_edge(1'b0);
        spclk_in = 1'b0;
        stall(1200);
        rnd_edge(1'b1);
        rnd_edge(1'b1);
        repeat (3) rnd_edge(1'b0);
    endtask

    task automatic test_en_drop();
        int fc;
        repeat (100 - m_idx) rnd_edge(1'b0);
        fc = m_frames;
        en = 1'b0;
        m_locked = 0; m_lost = 0; m_idx = 0;
        @(negedge mclk);
        tests++;
        if ({locked, sample_idx, sample_stb} !== {1'b0, 9'd0, 1'b0}) begin
            fails++;
            $display("FAIL en_drop: locked %b idx %0d stb %b required 0 0 0", locked, sample_idx, sample_stb);
        end
        for (int i = 0; i < 6; i++) do_edge(i[0], 4, 4);
        en = 1'b1;
        repeat (3) rnd_edge(1'b0);
        rnd_edge(1'b1);
        tests++;
        if (frame_cnt !== 16'(fc)) begin
            fails++;
            $display("FAIL en_drop_frame_cnt: got %0d required %0d", frame_cnt, fc);
        end
    endtask

    task automatic test_glitch();
`ifdef SPCLK_GLITCH_FILTER_EN
        spclk_in = 1'b1;
        @(negedge mclk);
        spclk_in = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge mclk);
            tests++;
            if (sample_stb !== 1'b0) begin
                fails++;
                $display("FAIL glitch_reject: got stb=%b required 0", sample_stb);
            end
        end
        do_edge(1'b0, 3, 4);
`else
        do_edge(1'b0, 1, 5);
`endif
    endtask

    task automatic test_random();
        bit s;
        for (int i = 0; i < 400; i++) begin
            if (m_locked && m_idx == 511) s = ($urandom_range(7) != 0);
            else s = ($urandom_range(63) == 0);
            rnd_edge(s);
        end
    endtask

    task automatic test_err_saturate();
        repeat (270) rnd_edge(1'b1);
        tests++;
        if (err_cnt !== 8'd255) begin
            fails++;
            $display("FAIL err_saturate: got %0d required 255", err_cnt);
        end
    endtask

    task automatic test_async_reset();
        rnd_edge(1'b0);
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge mclk);
        reset_n = 1'b1;
        model_reset();
        @(negedge mclk);
        check_all_zero("async_release");
        rnd_edge(1'b1);
    endtask

    initial begin
        test_reset();
        test_frames();
        test_short();
        test_long();
        test_timeout();
        test_en_drop();
        test_glitch();
        test_random();
        test_err_saturate();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
